dis_wei: RTL

- Weight distributor that sits directly upstream of the per-PEC weight controller.
- Prefetches weight words from the global weight buffer (GBFWEI) into a local FIFO and raises DISWEI_RdyFIFO once a full PEC weight block is buffered.
- On CTRLWEI_PlsFetch, streams exactly one block onto the shared PEC weight bus; the controller decides which PEC latches it.

---
 rtl/dis_wei.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dis_wei.sv
// Weight distributor: prefetches GBFWEI weight words into a local FIFO and
// streams exactly one PEC weight block onto the shared bus per fetch pulse.
module dis_wei #(
  parameter int WEI_WIDTH  = 64,
  parameter int BLK_WORDS  = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int NBLK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Reset,
  input  logic [NBLK_WIDTH-1:0] CFG_NumBlk,
  output logic                  DISGBF_EnRd,
  output logic [ADDR_WIDTH-1:0] DISGBF_Addr,
  input  logic [WEI_WIDTH-1:0]  GBFDIS_Dat,
  input  logic                  CTRLWEI_PlsFetch,
  output logic                  DISWEI_RdyFIFO,
  output logic [WEI_WIDTH-1:0]  DISWEIPEC_Wei,
  output logic                  DISWEIPEC_ValWei,
  output logic                  DISWEIPEC_LastWei,
  output logic                  DISWEI_ErrFetch
);

  // state  | meaning
  // R_IDLE | reader stopped, address parked at 0
  // R_RUN  | reader issues a GBFWEI read whenever FIFO space is guaranteed
  // S_IDLE | sender waits for a fetch pulse with a full block buffered
  // S_SEND | sender drains the rest of the current block, one word per cycle

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RW  = $clog2(BLK_WORDS + 1);
  localparam int MW  = ADDR_WIDTH + NBLK_WIDTH;

  typedef enum logic {R_IDLE = 1'b0, R_RUN  = 1'b1} rd_state_t;
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} snd_state_t;

  rd_state_t             rd_state, rd_state_nxt;
  snd_state_t            snd_state, snd_state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [WEI_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [RW-1:0]         remaining;

  logic [WEI_WIDTH-1:0]  wei_q;
  logic                  val_q;
  logic                  last_q;
  logic                  err_q;

  logic                  en_rd;
  logic                  start_acc;
  logic                  fetch_acc;
  logic                  pop;
  logic                  push;
  logic                  rdy;
  logic [NBLK_WIDTH-1:0] nblk_eff;
  logic [MW-1:0]         blk_prod;

  assign nblk_eff = (CFG_NumBlk == '0) ? NBLK_WIDTH'(1) : CFG_NumBlk;
  assign blk_prod = MW'(nblk_eff) * MW'(BLK_WORDS);

  // The read issued last cycle always lands in the FIFO now.
  assign push = inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      snd_state <= S_IDLE;
    end else begin
      rd_state  <= rd_state_nxt;
      snd_state <= snd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt  = rd_state;
    snd_state_nxt = snd_state;
    start_acc     = 1'b0;
    en_rd         = 1'b0;
    fetch_acc     = 1'b0;
    pop           = 1'b0;
    rdy           = (snd_state == S_IDLE) && (count >= CW'(BLK_WORDS)) && !Reset;

    case (rd_state)
      R_IDLE: begin
        if (Start) begin
          start_acc    = 1'b1;
          rd_state_nxt = R_RUN;
        end
      end
      R_RUN: begin
        // Counting the in-flight read as occupied keeps the FIFO from overflowing.
        en_rd = (CW1'(count) + CW1'(inflight)) < CW1'(FIFO_DEPTH);
      end
      default: rd_state_nxt = R_IDLE;
    endcase

    case (snd_state)
      S_IDLE: begin
        if (CTRLWEI_PlsFetch && rdy) begin
          fetch_acc     = 1'b1;
          pop           = 1'b1;
          snd_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (remaining != '0) begin
          pop = 1'b1;
        end else begin
          snd_state_nxt = S_IDLE;
        end
      end
      default: snd_state_nxt = S_IDLE;
    endcase

    if (Reset) begin
      rd_state_nxt  = R_IDLE;
      snd_state_nxt = S_IDLE;
      start_acc     = 1'b0;
      en_rd         = 1'b0;
      fetch_acc     = 1'b0;
      pop           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      wei_q     <= '0;
      val_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (Reset) begin
      addr      <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      wei_q     <= '0;
      val_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      inflight <= en_rd;

      if (start_acc) begin
        addr      <= '0;
        last_addr <= ADDR_WIDTH'(blk_prod - MW'(1));
      end else if (en_rd) begin
        addr <= (addr == last_addr) ? '0 : addr + ADDR_WIDTH'(1);
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      // Accept pops word 1; the down-counter covers the remaining words.
      if (fetch_acc) begin
        remaining <= RW'(BLK_WORDS - 1);
      end else if (pop) begin
        remaining <= remaining - RW'(1);
      end

      val_q  <= pop;
      last_q <= pop && !fetch_acc && (remaining == RW'(1));
      if (pop) wei_q <= mem[rd_ptr];

      if (CTRLWEI_PlsFetch && !rdy) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !Reset) mem[wr_ptr] <= GBFDIS_Dat;
  end

  assign DISGBF_EnRd       = en_rd;
  assign DISGBF_Addr       = addr;
  assign DISWEI_RdyFIFO    = rdy;
  assign DISWEIPEC_Wei     = wei_q;
  assign DISWEIPEC_ValWei  = val_q;
  assign DISWEIPEC_LastWei = last_q;
  assign DISWEI_ErrFetch   = err_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || Reset)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n || Reset)
    !(pop && (count == '0)));
`endif

endmodule
